// File: rtl/motor_fsm.sv
// motor_fsm -- garage-door style motor controller.
//
// A push-button (activate) starts the door travelling toward the opposite
// end stop. The motor stops when the end stop for the current direction
// is reached.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   activate       push-button request (synchronous to clk)
//   up_limit       1 = door at fully-up end stop
//   dn_limit       1 = door at fully-down end stop
//   motor_up       1 = drive motor upward (registered)
//   motor_dn       1 = drive motor downward (registered)
//   control_state  current state register
//
// Build option:
//   MOTOR_FSM_REVERSE_EN  when defined, a button press while moving
//                         reverses the direction of travel. When it is
//                         not defined, presses while moving are ignored.
//
// state     | meaning
// ----------+---------------------------------------
// DOOR_UP   | parked at the top end stop, motor off
// MOVING_DN | driving down until dn_limit
// DOOR_DN   | parked at the bottom end stop, motor off
// MOVING_UP | driving up until up_limit

module motor_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activate,
  input  logic       up_limit,
  input  logic       dn_limit,
  output logic       motor_up,
  output logic       motor_dn,
  output logic [1:0] control_state
);

  localparam logic [1:0] DOOR_UP   = 2'b00;
  localparam logic [1:0] MOVING_DN = 2'b01;
  localparam logic [1:0] DOOR_DN   = 2'b10;
  localparam logic [1:0] MOVING_UP = 2'b11;

  logic [1:0] state_q, state_d;
  logic       act_q;
  logic       motor_up_q, motor_dn_q;
  logic       trigger;

  // One-cycle event on the rising edge of the button; holding it does nothing.
  assign trigger = activate & ~act_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DOOR_UP: begin
        if (trigger) state_d = MOVING_DN;
      end
      MOVING_DN: begin
        // The end stop in the travel direction wins over a button press;
        // up_limit is deliberately not looked at here.
        if (dn_limit) begin
          state_d = DOOR_DN;
        end
`ifdef MOTOR_FSM_REVERSE_EN
        else if (trigger) begin
          state_d = MOVING_UP;
        end
`endif
      end
      DOOR_DN: begin
        if (trigger) state_d = MOVING_UP;
      end
      MOVING_UP: begin
        if (up_limit) begin
          state_d = DOOR_UP;
        end
`ifdef MOTOR_FSM_REVERSE_EN
        else if (trigger) begin
          state_d = MOVING_DN;
        end
`endif
      end
      default: state_d = DOOR_UP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DOOR_UP;
      act_q      <= 1'b0;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= activate;
      // Motor outputs decode the next state so they change on the same
      // edge as the state register; the two can never both be set.
      motor_up_q <= (state_d == MOVING_UP);
      motor_dn_q <= (state_d == MOVING_DN);
    end
  end

  assign motor_up      = motor_up_q;
  assign motor_dn      = motor_dn_q;
  assign control_state = state_q;

endmodule

// File: tb/tb_motor_fsm.sv
module tb_motor_fsm;

  logic       clk;
  logic       rst_n;
  logic       activate;
  logic       up_limit;
  logic       dn_limit;
  logic       motor_up;
  logic       motor_dn;
  logic [1:0] control_state;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       up;
    logic       dn;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  motor_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .activate     (activate),
    .up_limit     (up_limit),
    .dn_limit     (dn_limit),
    .motor_up     (motor_up),
    .motor_dn     (motor_dn),
    .control_state(control_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, wanted end of sequence");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Pops one scoreboard entry and compares it with the current outputs.
  task automatic compare_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, "_state"}, control_state, e.st);
    check_val({e.tag, "_up"}, {1'b0, motor_up}, {1'b0, e.up});
    check_val({e.tag, "_dn"}, {1'b0, motor_dn}, {1'b0, e.dn});
    check_val({e.tag, "_excl"}, {1'b0, motor_up & motor_dn}, 2'b00);
  endtask

  task automatic push_exp(input string tag, input logic [1:0] st, input logic up, input logic dn);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.up  = up;
    e.dn  = dn;
    sb_q.push_back(e);
  endtask

  // Drive inputs mid-cycle, expect the result of the next rising edge.
  task automatic step(input string tag, input logic act, input logic upl, input logic dnl,
                      input logic [1:0] st, input logic up, input logic dn);
    @(negedge clk);
    activate = act;
    up_limit = upl;
    dn_limit = dnl;
    push_exp(tag, st, up, dn);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    rst_n    = 1'b0;
    activate = 1'b0;
    up_limit = 1'b1;
    dn_limit = 1'b0;
    #35;
    push_exp("reset", 2'b00, 1'b0, 1'b0);
    compare_outputs();

    @(negedge clk);
    rst_n = 1'b1;

    // Down cycle
    step("idle_up",    1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("dn_start",   1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("dn_run1",    1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    step("dn_run2",    1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    step("dn_run3",    1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    step("dn_limit",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step("idle_dn",    1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

    // Up cycle; dn_limit still high while leaving the bottom is ignored
    step("up_start",   1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    step("up_ign_dn",  1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("up_run",   1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step("up_limit",   1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    // Held button: one transition only; up_limit ignored while moving down
    step("hold_start", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++)
      step("hold_run", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("hold_dnlim", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step("hold_rel",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

    // Press while moving up
    step("mu_start",   1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step("mu_run",     1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
`ifdef MOTOR_FSM_REVERSE_EN
    step("mu_press",   1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    step("rev_run",    1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
`else
    step("mu_press",   1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step("mu_run2",    1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    step("mu_limit",   1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("md_start",   1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("md_run",     1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
`endif
    // Press, dn_limit and up_limit together while moving down: limit wins
    step("dn_prio",    1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    step("prio_rel",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

    // Asynchronous reset mid-travel
    step("ar_up",      1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    step("ar_toplim",  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("ar_dn",      1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    @(negedge clk);
    activate = 1'b0;
    up_limit = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst", 2'b00, 1'b0, 1'b0);
    compare_outputs();

    // Button already high at the first edge after release counts as a press
    @(negedge clk);
    rst_n    = 1'b1;
    activate = 1'b1;
    step("post_rst",   1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    step("post_hold",  1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

    check_val("sb_drained", sb_q.size() == 0 ? 2'b01 : 2'b00, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_fsm.md
MOTOR_FSM -- requirements
Module: motor_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 activate  input  1  push-button request; synchronous to clk.
REQ-005 up_limit  input  1  1 = door at fully-up end stop.
REQ-006 dn_limit  input  1  1 = door at fully-down end stop.
REQ-007 motor_up  output  1  1 = drive motor upward.
REQ-008 motor_dn  output  1  1 = drive motor downward.
REQ-009 control_state  output  2  current FSM state encoding (REQ-012).
REQ-010 The block SHALL have no parameters.

Function
REQ-011 The block SHALL register activate into act_q each cycle; trigger = activate & ~act_q, a single-cycle rising-edge event.
REQ-012 States SHALL be DOOR_UP=2'b00, MOVING_DN=2'b01, DOOR_DN=2'b10, MOVING_UP=2'b11; control_state SHALL equal the state register.
REQ-013 DOOR_UP: trigger -> MOVING_DN; otherwise hold.
REQ-014 MOVING_DN: dn_limit=1 -> DOOR_DN; else reversal per REQ-023; otherwise hold.
REQ-015 DOOR_DN: trigger -> MOVING_UP; otherwise hold.
REQ-016 MOVING_UP: up_limit=1 -> DOOR_UP; else reversal per REQ-023; otherwise hold.
REQ-017 The limit of the current travel direction SHALL take priority over trigger in the same cycle.
REQ-018 The limit opposite the travel direction SHALL be ignored (MOVING_DN ignores up_limit, MOVING_UP ignores dn_limit), including when both limits are 1.
REQ-019 motor_dn and motor_up SHALL be registers, updated on the same edge as the state; motor_dn=1 exactly when the next state is MOVING_DN, and motor_up=1 exactly when the next state is MOVING_UP.
REQ-020 motor_up and motor_dn SHALL never be 1 simultaneously.
REQ-021 Latency: activate rising before edge N SHALL be sampled at edge N, and the motor output SHALL rise after edge N; limit sampled at edge N SHALL drop the motor output after edge N.
REQ-022 Holding activate high SHALL cause no further transitions until it is released and re-asserted.

Reset
REQ-024 While rst_n=0, the block SHALL force: state=DOOR_UP, control_state=2'b00, motor_up=0, motor_dn=0, act_q=0, independent of clk.
REQ-025 Reset assertion mid-travel SHALL stop the motor immediately (asynchronously).
REQ-026 Reset release SHALL be handled synchronously; the first transition can occur at the first rising edge after release, and activate=1 at that edge counts as a trigger.

Configuration
REQ-023 Macro MOTOR_FSM_REVERSE_EN: when defined, trigger in MOVING_DN with dn_limit=0 SHALL go to MOVING_UP, and trigger in MOVING_UP with up_limit=0 SHALL go to MOVING_DN, swapping the motor outputs in one cycle. When undefined, trigger SHALL be ignored in both moving states.

Verification
REQ-027 Down cycle: reset, up_limit=1, pulse activate -> motor_dn=1 and control_state=01 one edge later; dn_limit=1 after 4 cycles -> motor_dn=0 and control_state=10 on the next edge.
REQ-028 Up cycle: from DOOR_DN, pulse activate -> motor_up=1 and state=11; up_limit=1 after 6 cycles -> motor_up=0 and state=00 on the next edge; full sequence completes well within 2000 time units at a 20-unit clock period.
REQ-029 Activate held high for 10 cycles in DOOR_UP -> exactly one transition to MOVING_DN; no reversal occurs.
REQ-030 Trigger and dn_limit=1 on the same edge in MOVING_DN -> DOOR_DN; motor_up stays 0.
REQ-031 Trigger in MOVING_UP: with MOTOR_FSM_REVERSE_EN -> state 01, motor_dn=1, motor_up=0; without the macro -> state stays 11, motor_up stays 1.
REQ-032 rst_n=0 asynchronously during MOVING_DN -> motor_dn=0 and state=00 before the next clk edge; check motor_up & motor_dn == 0 every cycle of every test.
